// File: rtl/lifo.sv
// Parameterised LIFO stack with registered pop data and pointer-decoded full/empty.
// Optional LIFO_ERR_FLAGS_EN adds one-cycle overflow/underflow pulses.
module lifo #(
  parameter int N     = 32,
  parameter int depth = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic         rd_en,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
`ifdef LIFO_ERR_FLAGS_EN
  ,
  output logic         overflow,
  output logic         underflow
`endif
);

  localparam int ENTRIES = 2 ** depth;
  localparam logic [depth-1:0] IDX_ONE = {{(depth-1){1'b0}}, 1'b1};
  localparam logic [depth:0]   PTR_ONE = {{depth{1'b0}}, 1'b1};

  logic [N-1:0]     r_mem [ENTRIES];
  logic [depth:0]   r_ptr;
  logic [N-1:0]     r_dout;

  logic [depth-1:0] w_wr_idx;
  logic [depth-1:0] w_top_idx;
  logic             w_push;
  logic             w_pop;
  logic             w_swap;

  assign empty = (r_ptr == '0);
  assign full  = r_ptr[depth];
  assign dout  = r_dout;

  // A simultaneous push+pop on a non-empty stack replaces the top entry in place.
  assign w_swap    = wr_en & rd_en & ~empty;
  assign w_push    = wr_en & ~full & ~(rd_en & ~empty);
  assign w_pop     = rd_en & ~wr_en & ~empty;
  assign w_wr_idx  = r_ptr[depth-1:0];
  assign w_top_idx = r_ptr[depth-1:0] - IDX_ONE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push)
        r_mem[w_wr_idx] <= din;
      else if (w_swap)
        r_mem[w_top_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_dout <= '0;
    end else begin
      if (w_push)
        r_ptr <= r_ptr + PTR_ONE;
      else if (w_pop)
        r_ptr <= r_ptr - PTR_ONE;
      if (w_pop || w_swap)
        r_dout <= r_mem[w_top_idx];
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wr_en & ~rd_en & full;
      r_underflow <= rd_en & empty;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_lifo.sv
// Self-checking bench for lifo: a queue-based stack model pushes expected
// outputs per edge into a scoreboard, popped and compared after each edge.
module tb_lifo;

  localparam int N     = 32;
  localparam int DEPTH = 3;
  localparam int CAP   = 2 ** DEPTH;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic         rd_en;
  logic [N-1:0] din;
  logic [N-1:0] dout;
  logic         full;
  logic         empty;
`ifdef LIFO_ERR_FLAGS_EN
  logic         overflow;
  logic         underflow;
`endif

  lifo #(.N(N), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef LIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] dout;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         udf;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] stk[$];
  logic [N-1:0] m_dout;
  int           checks;
  int           errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic we, input logic re, input logic [N-1:0] d);
    exp_t e;
    logic m_full;
    logic m_empty;
    reset = rst;
    wr_en = we;
    rd_en = re;
    din   = d;
    m_full  = (stk.size() == CAP);
    m_empty = (stk.size() == 0);
    e.ovf = 1'b0;
    e.udf = 1'b0;
    if (rst) begin
      stk.delete();
      m_dout = '0;
    end else begin
      e.ovf = we && !re && m_full;
      e.udf = re && m_empty;
      if (we && re && !m_empty) begin
        m_dout = stk[stk.size()-1];
        stk[stk.size()-1] = d;
      end else if (we && !m_full) begin
        stk.push_back(d);
      end else if (re && !we && !m_empty) begin
        m_dout = stk.pop_back();
      end
    end
    e.dout  = m_dout;
    e.full  = (stk.size() == CAP);
    e.empty = (stk.size() == 0);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_underrun", 64'(1), 64'(0));
    end else begin
      e = sb_q.pop_front();
      chk("dout",  64'(dout),  64'(e.dout));
      chk("full",  64'(full),  64'(e.full));
      chk("empty", 64'(empty), 64'(e.empty));
`ifdef LIFO_ERR_FLAGS_EN
      chk("overflow",  64'(overflow),  64'(e.ovf));
      chk("underflow", 64'(underflow), 64'(e.udf));
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_dout = '0;
    reset  = 1'b1;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    din    = '0;

    // Reset two cycles, then idle.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("reset_empty", 64'(empty), 64'(1));

    // Fill to capacity, then one ignored push.
    for (int i = 1; i <= CAP; i++) step(1'b0, 1'b1, 1'b0, N'(i * 16));
    chk("full_after_8", 64'(full), 64'(1));
    step(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);

    // Drain with one extra pop on empty.
    for (int i = 0; i <= CAP; i++) step(1'b0, 1'b0, 1'b1, '0);
    chk("last_pop_holds", 64'(dout), 64'(32'h10));

    // Push, then push+pop swap, then pop.
    step(1'b0, 1'b1, 1'b0, 32'hAAAA);
    step(1'b0, 1'b1, 1'b1, 32'hBBBB);
    chk("swap_dout", 64'(dout), 64'(32'hAAAA));
    step(1'b0, 1'b0, 1'b1, '0);
    chk("swap_pop", 64'(dout), 64'(32'hBBBB));

    // Push+pop on empty: push proceeds, dout holds.
    step(1'b0, 1'b1, 1'b1, 32'h1234);
    step(1'b0, 1'b0, 1'b1, '0);

    // Swap while full.
    for (int i = 1; i <= CAP; i++) step(1'b0, 1'b1, 1'b0, N'(i * 16));
    step(1'b0, 1'b1, 1'b1, 32'h55);
    chk("full_swap_dout", 64'(dout), 64'(32'h80));
    step(1'b0, 1'b0, 1'b1, '0);
    chk("full_swap_pop", 64'(dout), 64'(32'h55));

    // Reset mid-operation with 4 entries and wr_en high, then ignored pop.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, N'(i));
    step(1'b1, 1'b1, 1'b0, 32'h99);
    chk("rst_mid_dout", 64'(dout), 64'(0));
    step(1'b0, 1'b0, 1'b1, '0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 49) == 0), 1'($urandom), 1'($urandom), N'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
